if_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage. It owns the program counter and issues word fetches to a synchronous instruction memory. It delivers a registered instruction, PC and valid bit to decode. It also handles hazard stalls, branch/jump redirects from EX, and the halt instruction decoded in ID.

---
 rtl/if_stage.sv | 128 ++++++++++++
 tb/tb_if_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: owns the PC, issues word fetches to a
// synchronous instruction memory, and handles stalls, EX redirects and the ID halt.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_IF,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_ID,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pc_plus4_ID,
    output logic        valid_ID,
    output logic        halted
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        f_valid_q, f_valid_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
    logic        valid_id_q, valid_id_d;

    logic [31:0] target;
    logic [31:0] rdata_eff;
    logic        fetch;
    logic        unused_redirect_bits;

    assign target               = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];
    // Memory output is only trustworthy the cycle after a request, so a stall parks it here.
    assign rdata_eff            = hold_valid_q ? hold_buf_q : imem_rdata;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        f_pc_d        = f_pc_q;
        f_valid_d     = f_valid_q;
        hold_buf_d    = hold_buf_q;
        hold_valid_d  = hold_valid_q;
        instr_id_d    = instr_id_q;
        pc_id_d       = pc_id_q;
        pc_plus4_id_d = pc_plus4_id_q;
        valid_id_d    = valid_id_q;
        fetch         = 1'b0;
        imem_addr     = pc_q;

        if (state_q == StRun) begin
            if (redirect) begin
                fetch        = 1'b1;
                imem_addr    = target;
                pc_d         = target + 32'd4;
                f_pc_d       = target;
                f_valid_d    = 1'b1;
                hold_valid_d = 1'b0;
                instr_id_d   = NOP_INSTR;
                valid_id_d   = 1'b0;
            end else if (halt_ID && valid_id_q && !stall_IF) begin
                state_d      = StHalted;
                f_valid_d    = 1'b0;
                hold_valid_d = 1'b0;
                instr_id_d   = NOP_INSTR;
                valid_id_d   = 1'b0;
            end else if (stall_IF) begin
                if (f_valid_q && !hold_valid_q) begin
                    hold_buf_d   = imem_rdata;
                    hold_valid_d = 1'b1;
                end
            end else begin
                fetch         = 1'b1;
                pc_d          = pc_q + 32'd4;
                f_pc_d        = pc_q;
                f_valid_d     = 1'b1;
                hold_valid_d  = 1'b0;
                instr_id_d    = f_valid_q ? rdata_eff : NOP_INSTR;
                pc_id_d       = f_pc_q;
                pc_plus4_id_d = f_pc_q + 32'd4;
                valid_id_d    = f_valid_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            f_pc_q        <= 32'h0;
            f_valid_q     <= 1'b0;
            hold_buf_q    <= 32'h0;
            hold_valid_q  <= 1'b0;
            instr_id_q    <= NOP_INSTR;
            pc_id_q       <= 32'h0;
            pc_plus4_id_q <= 32'h4;
            valid_id_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            f_pc_q        <= f_pc_d;
            f_valid_q     <= f_valid_d;
            hold_buf_q    <= hold_buf_d;
            hold_valid_q  <= hold_valid_d;
            instr_id_q    <= instr_id_d;
            pc_id_q       <= pc_id_d;
            pc_plus4_id_q <= pc_plus4_id_d;
            valid_id_q    <= valid_id_d;
        end
    end

    assign imem_ren    = fetch && rst_n;
    assign instr_ID    = instr_id_q;
    assign pc_ID       = pc_id_q;
    assign pc_plus4_ID = pc_plus4_id_q;
    assign valid_ID    = valid_id_q;
    assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scoreboard of expected IF/ID deliveries plus directed
// checks of fetch requests, stalls, redirects, halt and reset.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_IF = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_ID;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_ID;
    logic [31:0] pc_ID;
    logic [31:0] pc_plus4_ID;
    logic        valid_ID;
    logic        halted;

    logic        halt_en = 1'b0;
    logic [31:0] halt_pc = 32'h0;
    logic        last_stall = 1'b0;
    logic [31:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;

    if_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_IF    (stall_IF),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_ID     (halt_ID),
        .imem_ren    (imem_ren),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_ID    (instr_ID),
        .pc_ID       (pc_ID),
        .pc_plus4_ID (pc_plus4_ID),
        .valid_ID    (valid_ID),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    // Synchronous memory; garbage when no request so an unheld word cannot be reused.
    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= mem_word(imem_addr);
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    assign halt_ID = halt_en && valid_ID && (pc_ID == halt_pc);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) last_stall <= stall_IF;

    // A new IF/ID entry appears after every unstalled edge with valid_ID set.
    always @(negedge clk) begin
        if (rst_n && valid_ID && !last_stall) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", pc_ID, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", pc_ID, e);
                check("sb_instr", instr_ID, mem_word(e));
                check("sb_pc_plus4", pc_plus4_ID, e + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ren", {31'b0, imem_ren}, 32'd0);
        check("rst_instr", instr_ID, NOP);
        check("rst_pc", pc_ID, 32'h0);
        check("rst_pc4", pc_plus4_ID, 32'h4);
        check("rst_valid", {31'b0, valid_ID}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);

        // Streaming: cycle 0 after release fetches RESET_PC
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
        #1;
        check("first_ren", {31'b0, imem_ren}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        ticks(4);                                  // cycle 4
        check("pre_stall_pc", pc_ID, 32'h8);

        // Stall three cycles with 0x8 in ID
        stall_IF = 1'b1;
        #1;
        check("stall_ren", {31'b0, imem_ren}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();                                // cycles 5..7
            if (i == 2) stall_IF = 1'b0;
            check("stall_pc_frozen", pc_ID, 32'h8);
            check("stall_instr_frozen", instr_ID, mem_word(32'h8));
        end
        #1;
        check("release_ren", {31'b0, imem_ren}, 32'd1);
        check("release_addr", imem_addr, 32'h10);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        ticks(2);                                  // cycle 9
        check("pre_redir_pc", pc_ID, 32'h10);

        // Redirect to 0x203 (aligned to 0x200)
        redirect = 1'b1;
        redirect_pc = 32'h0000_0203;
        exp_q.push_back(32'h200);
        #1;
        check("redir_ren", {31'b0, imem_ren}, 32'd1);
        check("redir_addr", imem_addr, 32'h200);
        tick();                                    // cycle 10
        redirect = 1'b0;
        check("redir_bubble", {31'b0, valid_ID}, 32'd0);
        tick();                                    // cycle 11
        check("redir_target", pc_ID, 32'h200);

        // Redirect and stall together: redirect wins
        redirect = 1'b1;
        stall_IF = 1'b1;
        redirect_pc = 32'h0000_0303;
        exp_q.push_back(32'h300);
        #1;
        check("rs_ren", {31'b0, imem_ren}, 32'd1);
        check("rs_addr", imem_addr, 32'h300);
        tick();                                    // cycle 12
        redirect = 1'b0;
        stall_IF = 1'b0;
        check("rs_bubble", {31'b0, valid_ID}, 32'd0);
        tick();                                    // cycle 13
        check("rs_target", pc_ID, 32'h300);

        // Halt at 0x14, first seen under a stall
        redirect = 1'b1;
        redirect_pc = 32'h10;
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h14);
        halt_en = 1'b1;
        halt_pc = 32'h14;
        tick();                                    // cycle 14
        redirect = 1'b0;
        ticks(2);                                  // cycle 16
        check("halt_pc_in_id", pc_ID, 32'h14);
        stall_IF = 1'b1;
        tick();                                    // cycle 17
        stall_IF = 1'b0;
        check("halt_stalled", {31'b0, halted}, 32'd0);
        check("halt_stalled_valid", {31'b0, valid_ID}, 32'd1);
        tick();                                    // cycle 18
        check("halted", {31'b0, halted}, 32'd1);
        check("halted_valid", {31'b0, valid_ID}, 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h400;
        #1;
        check("halted_ren", {31'b0, imem_ren}, 32'd0);
        ticks(3);
        redirect = 1'b0;
        check("halted_stays", {31'b0, halted}, 32'd1);
        check("halted_valid_stays", {31'b0, valid_ID}, 32'd0);
        check("halted_ren_stays", {31'b0, imem_ren}, 32'd0);
        halt_en = 1'b0;

        // Asynchronous reset pulse restarts
        #1;
        rst_n = 1'b0;
        #1;
        check("rst2_halted", {31'b0, halted}, 32'd0);
        check("rst2_ren", {31'b0, imem_ren}, 32'd0);
        check("rst2_pc", pc_ID, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst2_addr", imem_addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        ticks(2);                                  // cycle 2: pc_ID = 0

        // Halt with concurrent redirect is squashed; target near top wraps
        halt_en = 1'b1;
        halt_pc = 32'h0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFB;
        tick();                                    // cycle 3
        halt_en = 1'b0;
        redirect = 1'b0;
        check("squash_halted", {31'b0, halted}, 32'd0);
        check("squash_bubble", {31'b0, valid_ID}, 32'd0);
        ticks(2);                                  // cycle 5
        check("wrap_pc4", pc_plus4_ID, 32'h0);
        ticks(2);                                  // cycle 7
        @(negedge clk);
        #1;
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
